// File: rtl/program_player.sv
// program_player: loadable program image replayed word by word onto the
// CPU instruction input, with per-word hold, one-shot/loop and abort.
module program_player #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int HOLD_W = 8
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ADDR_W:0]   length,
    input  logic [HOLD_W-1:0] hold,
    input  logic              loop_mode,
    input  logic              start,
    input  logic              stop,
    output logic [DATA_W-1:0] data_out,
    output logic              word_valid,
    output logic [ADDR_W-1:0] word_index,
    output logic              busy,
    output logic              done,
    output logic [7:0]        loop_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLAY,
        S_FINISH
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W+1)'(1);
    localparam logic [HOLD_W-1:0] ONE_H   = HOLD_W'(1);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_idx;
    logic [HOLD_W-1:0] r_hcnt;
    logic [HOLD_W-1:0] r_hold;
    logic [ADDR_W:0]   r_len;
    logic              r_loop;
    logic [7:0]        r_lc;

    logic [DATA_W-1:0] r_data_out;
    logic              r_word_valid;
    logic [ADDR_W-1:0] r_word_index;
    logic              r_busy;
    logic              r_done;
    logic [7:0]        r_loop_count;

    logic [ADDR_W:0]   w_len;
    logic [HOLD_W-1:0] w_hold;
    logic              w_last_tick;
    logic              w_last_word;
    logic              w_load;
    logic              w_play;
    logic              w_fin;

    always_comb begin
        w_len       = (length > DEPTH_L) ? DEPTH_L : length;
        w_hold      = (hold == '0) ? ONE_H : hold;
        w_last_tick = (r_hcnt == r_hold - ONE_H);
        w_last_word = ({1'b0, r_idx} == r_len - ONE_L);
        w_load      = load_en && ({1'b0, load_addr} < DEPTH_L);
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (w_len == '0) ? S_FINISH : S_PLAY;
                end
            end
            S_PLAY: begin
                if (stop) begin
                    w_next = S_IDLE;
                end else if (w_last_tick && w_last_word && !r_loop) begin
                    w_next = S_FINISH;
                end
            end
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_play = (r_state == S_PLAY);
        w_fin  = (r_state == S_FINISH);
    end

    // Playback datapath; loop_count is cleared only when a real pass starts.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_idx  <= '0;
            r_hcnt <= '0;
            r_len  <= '0;
            r_hold <= ONE_H;
            r_loop <= 1'b0;
            r_lc   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len  <= w_len;
                        r_hold <= w_hold;
                        r_loop <= loop_mode;
                        r_idx  <= '0;
                        r_hcnt <= '0;
                        if (w_len != '0) begin
                            r_lc <= '0;
                        end
                    end
                end
                S_PLAY: begin
                    if (!stop) begin
                        if (w_last_tick) begin
                            r_hcnt <= '0;
                            if (w_last_word) begin
                                r_idx <= '0;
                                if (r_loop && r_lc != 8'hFF) begin
                                    r_lc <= r_lc + 8'd1;
                                end
                            end else begin
                                r_idx <= r_idx + ONE_A;
                            end
                        end else begin
                            r_hcnt <= r_hcnt + ONE_H;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Image is write-protected outside IDLE.
    always_ff @(posedge CLK) begin
        if (reset && r_state == S_IDLE && w_load) begin
            r_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_data_out   <= '0;
            r_word_valid <= 1'b0;
            r_word_index <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_loop_count <= '0;
        end else begin
            r_data_out   <= w_play ? r_mem[r_idx] : '0;
            r_word_valid <= w_play;
            r_word_index <= w_play ? r_idx : '0;
            r_busy       <= w_play;
            r_done       <= w_fin;
            r_loop_count <= r_lc;
        end
    end

    assign data_out   = r_data_out;
    assign word_valid = r_word_valid;
    assign word_index = r_word_index;
    assign busy       = r_busy;
    assign done       = r_done;
    assign loop_count = r_loop_count;

endmodule

// File: tb/tb_program_player.sv
// Self-checking bench for program_player: elapsed-time reference model,
// directed scenarios with literal expectations, then random stimulus.
module tb_program_player;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int HOLD_W = 8;

    logic              CLK = 1'b0;
    logic              reset;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic [ADDR_W:0]   length;
    logic [HOLD_W-1:0] hold;
    logic              loop_mode;
    logic              start;
    logic              stop;
    logic [DATA_W-1:0] data_out;
    logic              word_valid;
    logic [ADDR_W-1:0] word_index;
    logic              busy;
    logic              done;
    logic [7:0]        loop_count;

    program_player #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .HOLD_W(HOLD_W)
    ) dut (
        .CLK       (CLK),
        .reset     (reset),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .length    (length),
        .hold      (hold),
        .loop_mode (loop_mode),
        .start     (start),
        .stop      (stop),
        .data_out  (data_out),
        .word_valid(word_valid),
        .word_index(word_index),
        .busy      (busy),
        .done      (done),
        .loop_count(loop_count)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: playback described by elapsed cycles e since start.
    // Word shown = (e / H) mod L; passes completed = e / (L*H).
    localparam int MI = 0;
    localparam int MP = 1;
    localparam int MF = 2;

    logic [DATA_W-1:0] img [DEPTH];
    int m_mode = MI;
    int e = 0;
    int L = 1;
    int H = 1;
    bit lp = 0;
    int m_lc = 0;

    logic [DATA_W-1:0] x_data = '0;
    int x_valid = 0;
    int x_idx = 0;
    int x_busy = 0;
    int x_done = 0;
    int x_lc = 0;

    always @(posedge CLK) begin
        if (!reset) begin
            x_data  = '0;
            x_valid = 0;
            x_idx   = 0;
            x_busy  = 0;
            x_done  = 0;
            x_lc    = 0;
            m_mode  = MI;
            m_lc    = 0;
        end else begin
            // outputs appear one edge after the state they describe
            x_valid = (m_mode == MP) ? 1 : 0;
            x_busy  = x_valid;
            x_done  = (m_mode == MF) ? 1 : 0;
            x_idx   = (m_mode == MP) ? (e / H) % L : 0;
            x_data  = (m_mode == MP) ? img[x_idx] : '0;
            x_lc    = m_lc;
            case (m_mode)
                MI: begin
                    if (load_en && int'(load_addr) < DEPTH)
                        img[load_addr] = load_data;
                    if (start) begin
                        L  = (int'(length) > DEPTH) ? DEPTH : int'(length);
                        H  = (hold == 0) ? 1 : int'(hold);
                        lp = loop_mode;
                        if (L == 0) begin
                            m_mode = MF;
                        end else begin
                            m_mode = MP;
                            e      = 0;
                            m_lc   = 0;
                        end
                    end
                end
                MP: begin
                    if (stop) begin
                        m_mode = MI;
                    end else begin
                        e++;
                        if (lp) begin
                            m_lc = e / (L * H);
                            if (m_lc > 255) m_lc = 255;
                        end else if (e == L * H) begin
                            m_mode = MF;
                        end
                    end
                end
                default: m_mode = MI;
            endcase
        end
    end

    always @(negedge CLK) begin
        chk("data_out",   32'(data_out),   32'(x_data));
        chk("word_valid", 32'(word_valid), 32'(x_valid));
        chk("word_index", 32'(word_index), 32'(x_idx));
        chk("busy",       32'(busy),       32'(x_busy));
        chk("done",       32'(done),       32'(x_done));
        chk("loop_count", 32'(loop_count), 32'(x_lc));
    end

    task automatic tick(int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic load_word(int a, logic [DATA_W-1:0] d);
        load_en   = 1'b1;
        load_addr = ADDR_W'(a);
        load_data = d;
        tick(1);
        load_en   = 1'b0;
    endtask

    // Returns just after the edge that samples start.
    task automatic play(int len, int hld, bit lpm);
        length    = (ADDR_W+1)'(len);
        hold      = HOLD_W'(hld);
        loop_mode = lpm;
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
    endtask

    logic [DATA_W-1:0] prog [8];
    int saw_done;

    initial begin
        prog[0] = 16'h4005; prog[1] = 16'h4105;
        prog[2] = 16'h1204; prog[3] = 16'h2B44;
        prog[4] = 16'h3462; prog[5] = 16'h1D80;
        prog[6] = 16'h26A0; prog[7] = 16'h7FCC;
        reset = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        length = '0; hold = '0; loop_mode = 1'b0;
        start = 1'b0; stop = 1'b0;
        tick(2);
        chk("reset_data", 32'(data_out), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) load_word(i, prog[i]);
        for (int i = 8; i < DEPTH; i++)
            load_word(i, DATA_W'($urandom));
        tick(2);

        // one-shot, 8 words held 4 cycles
        play(8, 4, 0);
        tick(1);
        chk("os_w0", 32'(data_out), 32'h4005);
        chk("os_busy", 32'(busy), 32'h1);
        tick(4);
        chk("os_w1", 32'(data_out), 32'h4105);
        chk("os_i1", 32'(word_index), 32'h1);
        tick(28);
        chk("os_done33", 32'(done), 32'h1);
        chk("os_busy_fall", 32'(busy), 32'h0);
        tick(1);
        chk("os_done_end", 32'(done), 32'h0);
        tick(3);

        // loop mode, 3 words, hold 1
        play(3, 1, 1);
        tick(4);
        chk("loop_lc1", 32'(loop_count), 32'h1);
        chk("loop_wrap", 32'(data_out), 32'h4005);
        tick(3);
        chk("loop_lc2", 32'(loop_count), 32'h2);
        stop = 1'b1; tick(1); stop = 1'b0;
        tick(3);

        // loop_count saturation
        play(1, 1, 1);
        tick(300);
        chk("loop_sat", 32'(loop_count), 32'd255);
        stop = 1'b1; tick(1); stop = 1'b0;
        tick(3);

        // abort during word 2
        play(8, 4, 0);
        tick(10);
        chk("abort_w2", 32'(data_out), 32'h1204);
        stop = 1'b1; tick(1); stop = 1'b0;
        tick(1);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_data", 32'(data_out), 32'h0);
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) saw_done = 1;
            tick(1);
        end
        chk("abort_no_done", 32'(saw_done), 32'h0);

        // loads while playing are ignored
        play(8, 1, 0);
        tick(1);
        load_en = 1'b1; load_addr = '0; load_data = 16'hDEAD;
        tick(3);
        load_en = 1'b0;
        tick(10);
        play(8, 1, 0);
        tick(1);
        chk("wprot_replay", 32'(data_out), 32'h4005);
        tick(12);

        // length 0
        play(0, 4, 0);
        tick(1);
        chk("len0_done", 32'(done), 32'h1);
        chk("len0_busy", 32'(busy), 32'h0);
        tick(3);

        // hold 0 behaves as 1
        play(2, 0, 0);
        tick(2);
        chk("hold0_w1", 32'(data_out), 32'h4105);
        tick(1);
        chk("hold0_done", 32'(done), 32'h1);
        tick(3);

        // length 20 clamps to DEPTH
        play(20, 1, 0);
        tick(16);
        chk("len20_i15", 32'(word_index), 32'd15);
        tick(1);
        chk("len20_done", 32'(done), 32'h1);
        tick(3);

        // hold 255
        play(2, 255, 0);
        tick(255);
        chk("h255_w0", 32'(data_out), 32'h4005);
        tick(1);
        chk("h255_w1", 32'(data_out), 32'h4105);
        tick(255);
        chk("h255_done", 32'(done), 32'h1);
        tick(3);

        // reset mid-playback then replay retained image
        play(8, 2, 0);
        tick(5);
        reset = 1'b0;
        tick(1);
        chk("rst_mid_busy", 32'(busy), 32'h0);
        chk("rst_mid_valid", 32'(word_valid), 32'h0);
        chk("rst_mid_done", 32'(done), 32'h0);
        reset = 1'b1;
        tick(20);
        play(8, 2, 0);
        tick(1);
        chk("rst_replay", 32'(data_out), 32'h4005);
        tick(20);

        // start held high through FINISH
        length = 1; hold = 1; loop_mode = 1'b0;
        start = 1'b1;
        tick(2);
        chk("b2b_busy", 32'(busy), 32'h1);
        tick(1);
        chk("b2b_done", 32'(done), 32'h1);
        tick(1);
        chk("b2b_gap", 32'(busy), 32'h0);
        tick(1);
        chk("b2b_restart", 32'(busy), 32'h1);
        start = 1'b0;
        tick(6);

        // random stimulus
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 299) != 0);
            load_en   = ($urandom_range(0, 3) == 0);
            load_addr = ADDR_W'($urandom);
            load_data = DATA_W'($urandom);
            start     = ($urandom_range(0, 7) == 0);
            stop      = ($urandom_range(0, 29) == 0);
            length    = (ADDR_W+1)'($urandom_range(0, 20));
            hold      = HOLD_W'($urandom_range(0, 3));
            loop_mode = ($urandom_range(0, 3) == 0);
            tick(1);
        end
        reset = 1'b1; start = 1'b0; stop = 1'b1; load_en = 1'b0;
        tick(2);
        stop = 1'b0;
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
